// File: rtl/sfp_seq_pkg.sv
// Shared encodings for the SFP pass sequencer: pass operations and FSM states.
package sfp_seq_pkg;

  typedef enum logic [1:0] {
    ModePass    = 2'b00,
    ModeAcc     = 2'b01,
    ModeRelu    = 2'b10,
    ModeIllegal = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRd   = 2'b01,
    StWr   = 2'b10,
    StFin  = 2'b11
  } state_e;

endpackage

// File: rtl/sfp_seq_if.sv
// Command, output-FIFO and PSUM-SRAM signals of the SFP pass sequencer.
interface sfp_seq_if #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned addr_bw = 11
) ();

  logic               start;
  logic [1:0]         mode;
  logic [addr_bw-1:0] base_addr;
  logic [addr_bw:0]   len;
  logic               ofifo_valid;
  logic [psum_bw-1:0] ofifo_in;
  logic [psum_bw-1:0] sram_q;
  logic               ofifo_rd;
  logic               sram_cen;
  logic               sram_wen;
  logic [addr_bw-1:0] sram_a;
  logic [psum_bw-1:0] sram_d;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, mode, base_addr, len, ofifo_valid, ofifo_in, sram_q,
    input  ofifo_rd, sram_cen, sram_wen, sram_a, sram_d, busy, done, err
  );

  modport slave (
    input  start, mode, base_addr, len, ofifo_valid, ofifo_in, sram_q,
    output ofifo_rd, sram_cen, sram_wen, sram_a, sram_d, busy, done, err
  );

endinterface

// File: rtl/sfp.sv
// Special-function processor: passthrough of FIFO data, accumulate into the
// partial sum, or ReLU of the partial sum (two's complement).
module sfp #(
  parameter int unsigned psum_bw = 16
) (
  input  logic [psum_bw-1:0] psum_in,
  input  logic [psum_bw-1:0] ofifo_in,
  input  logic               accum,
  input  logic               passthrough,
  output logic [psum_bw-1:0] sfp_out
);

  always_comb begin
    sfp_out = psum_in;
    if (passthrough) begin
      sfp_out = ofifo_in;
    end else if (accum) begin
      sfp_out = psum_in + ofifo_in;
    end else if (psum_in[psum_bw-1]) begin
      sfp_out = '0;
    end
  end

endmodule

// File: rtl/sfp_seq.sv
// Sequences one SFP pass over a PSUM SRAM region: read, transform, write back.
// Optional SFP_SEQ_STALL_CNT_EN adds a saturating stalled-read-cycle counter.
module sfp_seq
  import sfp_seq_pkg::*;
#(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned addr_bw = 11
) (
  input  logic        clk,
  input  logic        reset,
  sfp_seq_if.slave    bus
`ifdef SFP_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  state_e             state_q;
  mode_e              mode_q;
  logic [addr_bw-1:0] addr_q;
  logic [addr_bw:0]   cnt_q;
  logic               err_q;
  logic               stall;
  logic               ofifo_rd, sram_cen, sram_wen;

  // PASS/ACC need a FIFO word for every element; RELU only reads the SRAM.
  assign stall = (state_q == StRd) && (mode_q != ModeRelu) && !bus.ofifo_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= ModePass;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mode_q  <= mode_e'(bus.mode);
            addr_q  <= bus.base_addr;
            cnt_q   <= bus.len;
            err_q   <= (bus.mode == ModeIllegal);
            state_q <= (bus.len == '0 || bus.mode == ModeIllegal) ? StFin : StRd;
          end
        end
        StRd: begin
          if (!stall) state_q <= StWr;
        end
        StWr: begin
          addr_q  <= addr_q + addr_bw'(1);
          cnt_q   <= cnt_q - (addr_bw + 1)'(1);
          state_q <= (cnt_q > (addr_bw + 1)'(1)) ? StRd : StFin;
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes are masked during reset so an in-flight element is never written.
  always_comb begin
    ofifo_rd = 1'b0;
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    if (!reset) begin
      unique case (state_q)
        StRd: begin
          if (!stall) begin
            sram_cen = 1'b0;
            ofifo_rd = (mode_q != ModeRelu);
          end
        end
        StWr: begin
          sram_cen = 1'b0;
          sram_wen = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ofifo_rd = ofifo_rd;
  assign bus.sram_cen = sram_cen;
  assign bus.sram_wen = sram_wen;
  assign bus.sram_a   = reset ? '0 : addr_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StFin);
  assign bus.err      = err_q;

  sfp #(
    .psum_bw(psum_bw)
  ) u_sfp (
    .psum_in    (bus.sram_q),
    .ofifo_in   (bus.ofifo_in),
    .accum      (mode_q == ModeAcc),
    .passthrough(mode_q == ModePass),
    .sfp_out    (bus.sram_d)
  );

`ifdef SFP_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (state_q == StIdle && bus.start) begin
      stall_cnt_q <= '0;
    end else if (stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/sfp_seq.md
SFP_SEQ -- requirements
Module: sfp_seq

Interface
REQ-001 The block SHALL have parameter psum_bw, default 16: SFP data width, passed to the sfp instance.
REQ-002 The block SHALL have parameter addr_bw, default 11: PSUM SRAM address width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: pulse that begins a pass.
REQ-006 The block SHALL have port mode, input, 2: pass operation, 00 PASS, 01 ACC, 10 RELU, 11 illegal; latched on start.
REQ-007 The block SHALL have port base_addr, input, addr_bw: first PSUM address; latched on start.
REQ-008 The block SHALL have port len, input, addr_bw+1: element count; latched on start.
REQ-009 The block SHALL have port ofifo_valid, input, 1: the output FIFO is non-empty.
REQ-010 The block SHALL have port ofifo_in, input, psum_bw: FIFO data, valid the cycle after ofifo_rd.
REQ-011 The block SHALL have port sram_q, input, psum_bw: PSUM SRAM read data, valid the cycle after a read.
REQ-012 The block SHALL have port ofifo_rd, output, 1: FIFO pop strobe.
REQ-013 The block SHALL have port sram_cen, output, 1: SRAM chip enable, active-low.
REQ-014 The block SHALL have port sram_wen, output, 1: SRAM write enable, active-low.
REQ-015 The block SHALL have port sram_a, output, addr_bw: SRAM address.
REQ-016 The block SHALL have port sram_d, output, psum_bw: SRAM write data, which is the sfp output.
REQ-017 The block SHALL have ports busy, done and err, output, 1 each: pass in progress; one-cycle completion pulse; sticky illegal-mode flag.

Function
REQ-018 The FSM SHALL have states IDLE, RD, WR and FIN.
REQ-019 In IDLE, start SHALL latch mode, base_addr and len, clear err, and go to RD; if len==0 or mode==11 it SHALL go to FIN instead; mode==11 SHALL also set err.
REQ-020 In RD, when the latched mode is PASS or ACC and ofifo_valid==0, the block SHALL stall in RD with sram_cen=1 and ofifo_rd=0.
REQ-021 In RD when not stalled: sram_cen=0, sram_wen=1, sram_a=current address; ofifo_rd=1 for PASS/ACC and 0 for RELU; next state WR.
REQ-022 In WR: sram_cen=0, sram_wen=0, same address, sram_d=sfp output; the address SHALL then increment and the remaining count decrement; next state RD if count>1, else FIN.
REQ-023 Each element SHALL take 2 cycles when unstalled; a pass of N elements SHALL assert done exactly 2N+1 cycles after start is sampled.
REQ-024 sfp control SHALL be: PASS gives passthrough=1; ACC gives accum=1, passthrough=0; RELU gives both 0.
REQ-025 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-026 busy SHALL be 1 in RD, WR and FIN.
REQ-027 start while busy SHALL be ignored.
REQ-028 The address SHALL wrap modulo 2^addr_bw.
REQ-029 Outside RD and WR: sram_cen=1, sram_wen=1, ofifo_rd=0.

Reset
REQ-030 reset, including mid-pass, SHALL force IDLE on the next edge, with busy=0, done=0, err=0, ofifo_rd=0, sram_cen=1, sram_wen=1 and sram_a=0.
REQ-031 An in-flight element SHALL be abandoned without a write.

Configuration
REQ-032 With SFP_SEQ_STALL_CNT_EN defined, the block SHALL add output stall_cnt, 16 bits, saturating; it SHALL clear on start and on reset and increment each stalled RD cycle.
REQ-033 Without SFP_SEQ_STALL_CNT_EN, the port and counter SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-034 A shared package SHALL hold the mode encodings (PASS, ACC, RELU) and the FSM state encodings.
REQ-035 The block SHALL contain one sub-module, the existing sfp, fed sram_q as psum_in and ofifo_in, with accum and passthrough driven per REQ-024.

Verification
REQ-036 The bench SHALL cover: ACC, base 5, len 3, FIFO always valid, SRAM [10,20,30], FIFO [1,2,3] -> addresses 5..7 hold [11,22,33]; done at cycle 7 after start.
REQ-037 The bench SHALL cover: RELU, len 2, SRAM [0xFFF0, 0x0040] -> writes [0, 0x0040]; ofifo_rd never asserted.
REQ-038 The bench SHALL cover: PASS, len 2, ofifo_valid low for 4 cycles at first RD -> no SRAM access during the stall; done at cycle 9; stall_cnt=4 when SFP_SEQ_STALL_CNT_EN is defined.
REQ-039 The bench SHALL cover: mode 11 or len 0 -> done one cycle after start with no SRAM/FIFO access; err=1 only for mode 11.
REQ-040 The bench SHALL cover: base 0x7FF, len 2, ACC -> writes to 0x7FF then 0x000.
REQ-041 The bench SHALL cover: reset asserted in WR of element 2 of 4 -> IDLE next cycle, no further writes; a new start then runs correctly.
